// File: rtl/addsub_chunked.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock through a ripple slice.
// The result register doubles as an accumulator for the ACC+A / ACC-A operations.
module addsub_chunked #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDXW-1:0]  idx_q;
    logic             sub_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK-1:0] x_sl_d;
    logic [CHUNK-1:0] y_sl_d;
    logic [CHUNK:0]   sl_sum_d;
    logic [WIDTH-1:0] sum_d;
    logic             top_cin_d;

    // One slice of the ripple add; Y is inverted for subtraction, the +1 comes from the seeded carry
    always_comb begin
        x_sl_d    = x_q[int'(idx_q)*CHUNK +: CHUNK];
        y_sl_d    = y_q[int'(idx_q)*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
        sl_sum_d  = {1'b0, x_sl_d} + {1'b0, y_sl_d} + {{CHUNK{1'b0}}, carry_q};
        sum_d     = sum_q;
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = sl_sum_d[CHUNK-1:0];
        top_cin_d = x_sl_d[CHUNK-1] ^ y_sl_d[CHUNK-1] ^ sl_sum_d[CHUNK-1];
    end

    // Control FSM with all working state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= {WIDTH{1'b0}};
            y_q      <= {WIDTH{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
            idx_q    <= {IDXW{1'b0}};
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q     <= op[1] ? result_q : a;
                        y_q     <= op[1] ? a : b;
                        sub_q   <= op[0];
                        carry_q <= op[0];
                        idx_q   <= {IDXW{1'b0}};
                        sum_q   <= {WIDTH{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= sl_sum_d[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        // Flags are taken from the MSB slice in the same edge that publishes the result
                        result_q <= sum_d;
                        cout_q   <= sl_sum_d[CHUNK];
                        ovf_q    <= top_cin_d ^ sl_sum_d[CHUNK];
                        zero_q   <= (sum_d == {WIDTH{1'b0}});
                        idx_q    <= {IDXW{1'b0}};
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q    <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Scoreboard bench for addsub_chunked (WIDTH=12, CHUNK=3): stimulus pushes expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_addsub_chunked;
    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;
    logic          zero;

    always #5 clk = ~clk;

    addsub_chunked #(.WIDTH(W), .CHUNK(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           done_hist[$];
    bit           rec_on = 1'b0;
    logic [W-1:0] last_res;
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: checks pulse shape and busy length, and pops the scoreboard on each done
    initial begin : monitor
        int   busy_len;
        logic prev_done;
        exp_t e;
        busy_len  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_single_cycle", {31'b0, prev_done}, 32'd0);
                check("busy_cycles", busy_len, 32'd4);
                busy_len = 0;
                if (rec_on) done_hist.push_back(cyc);
                check("pending_expect", {31'b0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", {20'b0, result}, {20'b0, e.res});
                    check("cout", {31'b0, cout}, {31'b0, e.c});
                    check("ovf", {31'b0, ovf}, {31'b0, e.o});
                    check("zero", {31'b0, zero}, {31'b0, e.z});
                end
            end else if (busy === 1'b1) begin
                busy_len++;
            end else begin
                busy_len = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
        op = o; a = aa; b = bb; start = 1'b1;
        sb.push_back('{er, ec, eo, ez});
        @(posedge clk); #1;
        start = 1'b0;
        op = ~o; a = ~aa; b = bb ^ 12'h5A5;
        check("result_hold", {20'b0, result}, {20'b0, last_res});
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        last_res = er;
        wait_done();
    endtask

    initial begin
        int c0;
        int in_win;
        int k;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; last_res = '0;
        va[0] = 12'h010; vb[0] = 12'h020;
        va[1] = 12'h111; vb[1] = 12'h222;
        va[2] = 12'h0AA; vb[2] = 12'h055;
        va[3] = 12'h800; vb[3] = 12'h800;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_result", {20'b0, result}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
        @(posedge clk); #1;

        do_op(2'b00, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b1, 1'b0);
        do_op(2'b00, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b0, 1'b1);
        do_op(2'b01, 12'h005, 12'h005, 12'h000, 1'b1, 1'b0, 1'b1);
        do_op(2'b01, 12'h003, 12'h005, 12'hFFE, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("acc_cleared", {20'b0, result}, 32'd0);
        last_res = '0;
        do_op(2'b10, 12'h100, 12'h000, 12'h100, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 12'h100, 12'h000, 12'h200, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 12'h100, 12'h000, 12'h300, 1'b0, 1'b0, 1'b0);
        do_op(2'b11, 12'h400, 12'h000, 12'hF00, 1'b0, 1'b0, 1'b0);

        // start held high for 20 edges; operands change mid-run and only apply to the next launch
        sb.push_back('{12'h030, 1'b0, 1'b0, 1'b0});
        sb.push_back('{12'h333, 1'b0, 1'b0, 1'b0});
        sb.push_back('{12'h0FF, 1'b0, 1'b0, 1'b0});
        sb.push_back('{12'h000, 1'b1, 1'b1, 1'b1});
        rec_on = 1'b1;
        op = 2'b00; a = va[0]; b = vb[0]; start = 1'b1;
        c0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) c0 = cyc;
            if (i == 19) begin
                start = 1'b0;
            end else begin
                a = va[(i + 6) / 6];
                b = vb[(i + 6) / 6];
            end
        end
        k = 0;
        while (sb.size() > 0 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("held_queue_drained", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rec_on = 1'b0;
        in_win = 0;
        foreach (done_hist[i]) if (done_hist[i] < c0 + 20) in_win++;
        check("held_done_in_window", in_win, 32'd3);
        check("held_done_total", done_hist.size(), 32'd4);
        for (int i = 1; i < done_hist.size(); i++)
            check("held_done_gap", done_hist[i] - done_hist[i-1], 32'd6);
        last_res = 12'h000;

        // Reset during the second RUN cycle aborts without a done pulse
        op = 2'b00; a = 12'h123; b = 12'h456; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", {20'b0, result}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        last_res = '0;
        do_op(2'b00, 12'h123, 12'h456, 12'h579, 1'b0, 1'b0, 1'b0);

        k = 0;
        while (sb.size() > 0 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("final_queue_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_chunked.md
ADDSUB_CHUNKED -- requirements
Module: addsub_chunked

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 3, bits processed per clock cycle. WIDTH SHALL be a multiple of CHUNK. NSLICE = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: 00 = A+B, 01 = A-B, 10 = ACC+A, 11 = ACC-A.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, WIDTH bits: last completed result; it also serves as the accumulator ACC.
REQ-011 The block SHALL have ports cout, ovf and zero, output, 1 bit each: carry out of MSB, two's-complement overflow, and result==0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE. Transitions:
- IDLE->RUN on start=1.
- RUN->DONE after NSLICE slices.
- DONE->IDLE unconditionally after one cycle.
REQ-013 On the accepting edge the block SHALL:
- latch the first operand X (a for op 00/01; result for op 10/11) and the second operand Y (b for op 00/01; a for op 10/11) into working registers;
- latch the sub flag = op[0];
- clear the slice index to 0;
- set the carry register to sub.
REQ-014 Subtraction SHALL be performed as X + ~Y + 1 (Y inverted, initial carry 1); addition SHALL use initial carry 0.
REQ-015 Each RUN edge SHALL add slice [idx*CHUNK +: CHUNK] of X and of (Y or ~Y) plus the carry register, write that sum slice into the working sum register, store the slice carry-out into the carry register, and increment idx.
REQ-016 At the final slice edge (idx = NSLICE-1), the block SHALL update result, cout, ovf and zero in the same edge it enters DONE:
- cout = carry out of bit WIDTH-1;
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
- zero = (final sum == 0).
REQ-017 Latency SHALL be: start accepted at edge t0, busy=1 for the NSLICE cycles following edges t0..t0+NSLICE-1, done=1 for exactly the one cycle following edge t0+NSLICE.
REQ-018 result, cout, ovf and zero SHALL change only at completion edges and SHALL hold otherwise, including during RUN of the next operation.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing. A start held high continuously SHALL launch a new operation on the first IDLE edge, giving one operation per NSLICE+2 cycles.
REQ-020 a, b and op changes after acceptance SHALL NOT affect the operation in progress.
REQ-021 In subtraction, cout=1 SHALL mean no borrow (X >= Y unsigned).
REQ-022 Wrap-around: the result SHALL be the sum modulo 2^WIDTH; the bits beyond WIDTH SHALL be reported only via cout.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL:
- enter IDLE;
- clear idx, the carry register and the working registers;
- set result=0, cout=0, ovf=0, zero=0, busy=0, done=0.
REQ-024 Reset SHALL take priority over start and over RUN progress. Reset mid-RUN SHALL abort with no done pulse and no result update other than clearing to 0.
REQ-025 After reset, ACC (result) SHALL equal 0, so that op 10/11 starts from 0.

Verification (WIDTH=12, CHUNK=3, NSLICE=4)
REQ-026 The bench SHALL cover: op=00, a=0x7FF, b=0x001 -> result=0x800, cout=0, ovf=1, zero=0; done one cycle after 4 busy cycles.
REQ-027 The bench SHALL cover: op=00, a=0xFFF, b=0x001 -> result=0x000, cout=1, ovf=0, zero=1.
REQ-028 The bench SHALL cover:
- op=01, a=5, b=5 -> result=0x000, cout=1, zero=1;
- then op=01, a=3, b=5 -> result=0xFFE, cout=0, ovf=0.
REQ-029 The bench SHALL cover, after reset: op=10, a=0x100 three times -> result=0x300; then op=11, a=0x400 -> result=0xF00, cout=0, ovf=0.
REQ-030 The bench SHALL cover start held high for 20 cycles -> exactly 3 done pulses, 6 cycles apart; operand changes during busy not reflected in the result.
REQ-031 The bench SHALL cover rst pulsed at the second RUN cycle of 0x123+0x456 -> busy=0, result=0, no done; the next op=00, a=0x123, b=0x456 -> result=0x579.
